// File: rtl/gun_shot_ctrl.sv
// gun_shot_ctrl
//   Light-gun front end. It synchronises and debounces the raw trigger pin.
//   It then runs the two-frame shot test: one all-black frame, then one
//   target-only frame, sampling the photodetector during each. It emits a
//   one-cycle hit or miss verdict and the draw requests for the draw stage.
//
// Ports
//   clk                65 MHz pixel clock
//   rst                asynchronous reset, active high
//   gun_trigger        raw trigger pin, asynchronous, pressed = 1
//   gun_photodetector  raw photodetector pin, asynchronous, polarity set by PD_ACTIVE_LOW
//   frame_start        one-cycle pulse on the first cycle of each frame
//   draw_black         high for the whole black test frame
//   draw_target        high for the whole target test frame
//   hit                one-cycle pulse: valid shot hit the target
//   miss               one-cycle pulse: missed, or light seen in the black frame
//   busy               high whenever the shot FSM is not idle
module gun_shot_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned HIT_MIN_CYCLES  = 64,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned PD_ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic gun_trigger,
    input  logic gun_photodetector,
    input  logic frame_start,
    output logic draw_black,
    output logic draw_target,
    output logic hit,
    output logic miss,
    output logic busy
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PD_W = $clog2(HIT_MIN_CYCLES) + 1;
    localparam int unsigned CL_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PD_W-1:0] HIT_MIN  = PD_W'(HIT_MIN_CYCLES);
    localparam logic [CL_W-1:0] COOL_END = CL_W'(COOLDOWN_FRAMES);
    localparam logic            PD_POL   = (PD_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BLACK,
        TARGET,
        VERDICT,
        COOL
    } state_t;

    state_t state, next;

    logic            trig_s1, trig_s2;
    logic            pd_s1, pd_s2;
    logic [1:0]      sync_v;
    logic            need_release;
    logic            trig_db;
    logic [DB_W-1:0] db_cnt;
    logic            trig_rise;
    logic            cheat;
    logic [PD_W-1:0] pd_cnt;
    logic [CL_W-1:0] cool_cnt;
    logic            pd;
    logic            db_flip;

    assign pd      = pd_s2 ^ PD_POL;
    assign db_flip = (trig_s2 != trig_db) && (db_cnt == DB_LAST);

    // Synchronisers and debounce. sync_v marks when the synchroniser
    // holds real pin samples. need_release blocks a trigger that is held
    // through reset from firing. Only a release, seen with a valid sync
    // and a debounced 0, re-enables trig_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1      <= 1'b0;
            trig_s2      <= 1'b0;
            pd_s1        <= 1'b0;
            pd_s2        <= 1'b0;
            sync_v       <= '0;
            need_release <= 1'b1;
            trig_db      <= 1'b0;
            db_cnt       <= '0;
            trig_rise    <= 1'b0;
        end else begin
            trig_s1   <= gun_trigger;
            trig_s2   <= trig_s1;
            pd_s1     <= gun_photodetector;
            pd_s2     <= pd_s1;
            sync_v    <= {sync_v[0], 1'b1};
            if (sync_v[1] && !trig_s2 && !trig_db)
                need_release <= 1'b0;
            if (trig_s2 == trig_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                trig_db <= ~trig_db;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            trig_rise <= db_flip && !trig_db && !need_release;
        end
    end

    // Shot bookkeeping: cheat flag, target-frame light count, cooldown frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cheat    <= 1'b0;
            pd_cnt   <= '0;
            cool_cnt <= '0;
        end else begin
            state <= next;
            if (state == VERDICT)
                cheat <= 1'b0;
            else if (state == BLACK && pd)
                cheat <= 1'b1;
            if (state == VERDICT)
                pd_cnt <= '0;
            else if (state == TARGET && pd && pd_cnt != '1)
                pd_cnt <= pd_cnt + 1'b1;
            if (state != COOL)
                cool_cnt <= '0;
            else if (frame_start && cool_cnt != COOL_END)
                cool_cnt <= cool_cnt + 1'b1;
        end
    end

    // The outputs are decoded from the state register. The draw requests
    // change on the same edge that the frame_start is taken.
    always_comb begin
        next        = state;
        draw_black  = 1'b0;
        draw_target = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:    if (trig_rise) next = ARM;
            ARM:     if (frame_start) next = BLACK;
            BLACK: begin
                draw_black = 1'b1;
                if (frame_start) next = TARGET;
            end
            TARGET: begin
                draw_target = 1'b1;
                if (frame_start) next = VERDICT;
            end
            VERDICT: begin
                if (!cheat && pd_cnt >= HIT_MIN) hit = 1'b1;
                else                            miss = 1'b1;
                next = COOL;
            end
            COOL:    if (cool_cnt == COOL_END && !trig_db) next = IDLE;
            default: next = IDLE;
        endcase
    end

endmodule
